// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time,
// presents {pc, inst, valid} to the fetch-to-decode register and keeps a
// one-entry skid buffer so a response landing during a stall is retained.
//
// state | meaning
// ------+--------------------------------------------------------------
// REQ   | free to issue a read (blocked while the skid buffer is full)
// WAIT  | read accepted, waiting for its rvalid
// DRAIN | read abandoned by a redirect, discard its rvalid when it comes
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_valid
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_inst;
  logic        r_out_valid;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_inst;
  logic        r_buf_valid;

  logic        w_req;
  logic        w_accept;
  logic        w_consume;
  logic        w_resp;
  logic        w_to_slot;
  logic        w_outstanding;
  logic [31:0] w_redirect_pc;

  assign w_redirect_pc = i_redirect_pc & ~32'd3;
  assign w_req         = (r_state == S_REQ) & ~r_buf_valid & ~rst;
  assign w_accept      = w_req & i_imem_ready;
  assign w_consume     = r_out_valid & ~i_stall;
  assign w_resp        = (r_state == S_WAIT) & i_imem_rvalid;
  // A response goes straight to the slot only if the slot frees up this edge
  // and nothing older is waiting in the skid buffer.
  assign w_to_slot     = w_resp & (~r_out_valid | w_consume) & ~r_buf_valid;
  // A read is still in flight after this edge: it must be drained on redirect.
  assign w_outstanding = ((r_state == S_WAIT) & ~i_imem_rvalid)
                       | w_accept
                       | ((r_state == S_DRAIN) & ~i_imem_rvalid);

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_pc;
  assign o_pc        = r_out_pc;
  assign o_inst      = r_out_inst;
  assign o_valid     = r_out_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_REQ;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; redirect overrides everything else.
  always_comb begin
    w_state_nxt = r_state;
    if (i_redirect) begin
      w_state_nxt = w_outstanding ? S_DRAIN : S_REQ;
    end else begin
      case (r_state)
        S_REQ:   if (w_accept)      w_state_nxt = S_WAIT;
        S_WAIT:  if (i_imem_rvalid) w_state_nxt = S_REQ;
        S_DRAIN: if (i_imem_rvalid) w_state_nxt = S_REQ;
        default:                    w_state_nxt = S_REQ;
      endcase
    end
  end

  // PC advance on accepted request, reload on redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_ADDR;
      r_req_pc <= 32'h0;
    end else if (i_redirect) begin
      r_pc <= w_redirect_pc;
    end else if (w_accept) begin
      r_req_pc <= r_pc;
      r_pc     <= r_pc + 32'd4;
    end
  end

  // Output slot: load a fresh response, refill from the buffer, or empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= 32'h0;
      r_out_inst  <= NOP_INST;
    end else if (i_redirect) begin
      r_out_valid <= 1'b0;
      r_out_inst  <= NOP_INST;
    end else if (w_to_slot) begin
      r_out_valid <= 1'b1;
      r_out_pc    <= r_req_pc;
      r_out_inst  <= i_imem_rdata;
    end else if (w_consume) begin
      if (r_buf_valid) begin
        r_out_valid <= 1'b1;
        r_out_pc    <= r_buf_pc;
        r_out_inst  <= r_buf_inst;
      end else begin
        r_out_valid <= 1'b0;
        r_out_inst  <= NOP_INST;
      end
    end
  end

  // Skid buffer: catches a response that cannot enter the stalled slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_buf_pc    <= 32'h0;
      r_buf_inst  <= 32'h0;
    end else if (i_redirect) begin
      r_buf_valid <= 1'b0;
    end else if (w_resp && !w_to_slot) begin
      r_buf_valid <= 1'b1;
      r_buf_pc    <= r_req_pc;
      r_buf_inst  <= i_imem_rdata;
    end else if (w_consume && r_buf_valid) begin
      r_buf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory model plus a queue-based reference of the
// instructions held by the stage (slot + skid) checked every cycle.
module tb_fetch_unit;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_stall, i_redirect, i_imem_ready, i_imem_rvalid;
  logic [31:0] i_redirect_pc, i_imem_rdata;
  logic        o_imem_req, o_valid;
  logic [31:0] o_imem_addr, o_pc, o_inst;

  fetch_unit #(.RESET_ADDR(RESET_ADDR), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .i_stall(i_stall), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .o_imem_req(o_imem_req),
    .o_imem_addr(o_imem_addr), .i_imem_ready(i_imem_ready),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_pc(o_pc), .o_inst(o_inst), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference state: instructions held by the stage, in hand-off order
  logic [63:0] q[$];
  logic [31:0] m_pc;
  bit          m_pend, m_stale;
  logic [31:0] m_pend_addr, mem_addr;
  int          m_cnt;
  int          ready_mode = 2;  // 0 random, 1 low, 2 high
  int          lat_mode   = 0;  // extra cycles before rvalid, -1 random

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [97:0] model_vec();
    logic [63:0] h;
    bit v;
    v = (q.size() > 0);
    h = v ? q[0] : {32'h0, NOP};
    return {v, (!m_pend && q.size() < 2), m_pc, h};
  endfunction

  function automatic logic [97:0] dut_vec();
    return {o_valid, o_imem_req, o_imem_addr, (o_valid ? o_pc : 32'h0), o_inst};
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc = RESET_ADDR;
    m_pend = 0;
    m_stale = 0;
    m_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_stall = 0; i_redirect = 0; i_redirect_pc = 0;
    i_imem_ready = 0; i_imem_rvalid = 0; i_imem_rdata = 0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one cycle of inputs at the negedge, advance the reference for the
  // coming edge, and return at the following negedge.
  task automatic tick(input bit stall, input bit redir, input logic [31:0] tgt);
    bit ready, deliver, accept;
    logic [31:0] pc_before;
    ready   = (ready_mode == 0) ? ($urandom_range(0, 1) == 1) : (ready_mode == 2);
    deliver = m_pend && (m_cnt == 0);
    i_stall       = stall;
    i_redirect    = redir;
    i_redirect_pc = tgt;
    i_imem_ready  = ready;
    i_imem_rvalid = deliver;
    i_imem_rdata  = deliver ? memf(mem_addr) : $urandom();
    accept    = !m_pend && (q.size() < 2) && ready;
    pc_before = m_pc;
    if (redir) begin
      q.delete();
      if (m_pend && !deliver) m_stale = 1;
      m_pc = tgt & ~32'd3;
    end else begin
      if (q.size() > 0 && !stall) void'(q.pop_front());
      if (deliver && !m_stale) q.push_back({m_pend_addr, memf(m_pend_addr)});
      if (accept) m_pc = m_pc + 32'd4;
    end
    if (deliver) begin
      m_pend = 0;
      m_stale = 0;
    end else if (m_pend) begin
      m_cnt--;
    end
    if (accept) begin
      m_pend      = 1;
      m_stale     = redir;
      m_pend_addr = pc_before;
      mem_addr    = o_imem_addr;
      m_cnt       = (lat_mode < 0) ? int'($urandom_range(0, 2)) : lat_mode;
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_stall = 0; i_redirect = 0; i_redirect_pc = 0;
    i_imem_ready = 0; i_imem_rvalid = 0; i_imem_rdata = 0;
    #2;
    vectors++;
    if ({o_valid, o_imem_req, o_pc, o_inst, o_imem_addr} !== {1'b0, 1'b0, 32'h0, NOP, RESET_ADDR}) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b req=%b pc=%h inst=%h addr=%h", o_valid, o_imem_req, o_pc, o_inst, o_imem_addr);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== RESET_ADDR) begin
      miscompares++;
      $display("FAIL reset_release: got req=%b addr=%h, want req=1 addr=%h", o_imem_req, o_imem_addr, RESET_ADDR);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    do_reset();
    ready_mode = 2; lat_mode = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(0, 0, 0);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL stream c%0d: got %h want %h", i, dut_vec(), model_vec());
      end
      if (i == 2) begin
        vectors++;
        if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_inst !== 32'hA5A5_0000) begin
          miscompares++;
          $display("FAIL stream_first: got v=%b pc=%h inst=%h want 1/0/a5a50000", o_valid, o_pc, o_inst);
        end
      end
      if (i == 3) begin
        vectors++;
        if (o_valid !== 1'b0 || o_inst !== NOP) begin
          miscompares++;
          $display("FAIL stream_gap: got v=%b inst=%h want 0/%h", o_valid, o_inst, NOP);
        end
      end
      if (i == 8) begin
        vectors++;
        if (o_valid !== 1'b1 || o_pc !== 32'd12) begin
          miscompares++;
          $display("FAIL stream_fourth: got v=%b pc=%h want 1/0000000c", o_valid, o_pc);
        end
      end
    end
  endtask

  task automatic test_stall_skid();
    do_reset();
    ready_mode = 2; lat_mode = 0;
    for (int i = 0; i < 14; i++) begin
      tick(i >= 2 && i < 8, 0, 0);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL stall c%0d: got %h want %h", i, dut_vec(), model_vec());
      end
      if (i == 7) begin
        vectors++;
        if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_imem_req !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_hold: got v=%b pc=%h req=%b want 1/0/0", o_valid, o_pc, o_imem_req);
        end
      end
      if (i == 8) begin
        vectors++;
        if (o_valid !== 1'b1 || o_pc !== 32'd4 || o_inst !== memf(32'd4)) begin
          miscompares++;
          $display("FAIL stall_release: got v=%b pc=%h inst=%h want 1/4", o_valid, o_pc, o_inst);
        end
      end
    end
  endtask

  task automatic test_ready_delay();
    do_reset();
    ready_mode = 1; lat_mode = 1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0);
      vectors++;
      if (o_imem_req !== 1'b1 || o_imem_addr !== RESET_ADDR || o_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_hold c%0d: got req=%b addr=%h v=%b", i, o_imem_req, o_imem_addr, o_valid);
      end
    end
    ready_mode = 2;
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL ready_delay c%0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_redirect_wait();
    bit seen;
    do_reset();
    ready_mode = 2; lat_mode = 2;
    tick(0, 0, 0);
    tick(0, 1, 32'h0000_1002);
    vectors++;
    if (o_valid !== 1'b0 || o_imem_addr !== 32'h0000_1000 || o_imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_wait: got v=%b addr=%h req=%b want 0/00001000/0", o_valid, o_imem_addr, o_imem_req);
    end
    lat_mode = 0;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick(0, 0, 0);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL redir_wait c%0d: got %h want %h", i, dut_vec(), model_vec());
      end
      seen = (o_valid === 1'b1);
    end
    vectors++;
    if (!seen || o_pc !== 32'h0000_1000 || o_inst !== memf(32'h0000_1000)) begin
      miscompares++;
      $display("FAIL redir_target: got seen=%b pc=%h inst=%h want 00001000", seen, o_pc, o_inst);
    end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    ready_mode = 2; lat_mode = 0;
    tick(0, 0, 0);
    tick(0, 1, 32'h0000_2000);
    vectors++;
    if (o_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h0000_2000) begin
      miscompares++;
      $display("FAIL redir_rvalid: got v=%b req=%b addr=%h want 0/1/00002000", o_valid, o_imem_req, o_imem_addr);
    end
    for (int i = 0; i < 4; i++) tick(i >= 2, 0, 0);
    tick(1, 1, 32'h0000_3001);
    vectors++;
    if (o_valid !== 1'b0 || o_inst !== NOP || o_imem_req !== 1'b1 || o_imem_addr !== 32'h0000_3000) begin
      miscompares++;
      $display("FAIL redir_buf: got v=%b inst=%h req=%b addr=%h", o_valid, o_inst, o_imem_req, o_imem_addr);
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL redir_flush c%0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] seen[$];
    do_reset();
    ready_mode = 2; lat_mode = 0;
    tick(0, 1, 32'hFFFF_FFFC);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0);
      if (o_valid === 1'b1) seen.push_back(o_pc);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL wrap c%0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    vectors++;
    if (seen.size() < 2) begin
      miscompares++;
      $display("FAIL wrap_seq: got %0d deliveries want >=2", seen.size());
    end else if (seen[0] !== 32'hFFFF_FFFC || seen[1] !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_seq: got %h,%h want fffffffc,00000000", seen[0], seen[1]);
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    do_reset();
    ready_mode = 2; lat_mode = 0;
    tick(0, 0, 0);
    tick(0, 0, 0);
    lat_mode = 2;
    tick(1, 0, 0);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({o_valid, o_imem_req, o_pc, o_inst, o_imem_addr} !== {1'b0, 1'b0, 32'h0, NOP, RESET_ADDR}) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b req=%b pc=%h inst=%h addr=%h", o_valid, o_imem_req, o_pc, o_inst, o_imem_addr);
    end
    i_stall = 0; i_imem_rvalid = 0; i_imem_ready = 0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    lat_mode = 0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick(0, 0, 0);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL async_refetch c%0d: got %h want %h", i, dut_vec(), model_vec());
      end
      seen = (o_valid === 1'b1);
    end
    vectors++;
    if (!seen || o_pc !== RESET_ADDR) begin
      miscompares++;
      $display("FAIL async_first: got seen=%b pc=%h want %h", seen, o_pc, RESET_ADDR);
    end
  endtask

  task automatic test_random();
    do_reset();
    ready_mode = 0; lat_mode = -1;
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom());
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL random c%0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_skid();
    test_ready_delay();
    test_redirect_wait();
    test_redirect_flush();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
